// File: rtl/d5m_axis_packer_pkg.sv
// Shared pixel beat type for the D5M to AXI4-Stream packer and its FIFO.
package generic_pack;

    localparam int DATA_W_DEF = 24;

    typedef struct packed {
        logic                  user;
        logic                  last;
        logic [DATA_W_DEF-1:0] data;
    } axis_pixel_t;

endpackage

// File: rtl/d5m_axis_fifo.sv
// Show-ahead synchronous FIFO of axis_pixel_t; write-to-visible latency 1 cycle, no bypass.
// A push while full lands only if a pop happens the same cycle; the caller decides what a drop means.
module d5m_axis_fifo
    import generic_pack::*;
#(
    parameter int FIFO_DEPTH = 16
) (
    input  logic        pixclk,
    input  logic        reset,
    input  logic        push_i,
    input  axis_pixel_t push_dat_i,
    input  logic        pop_i,
    output axis_pixel_t head_o,
    output logic        full_o,
    output logic        empty_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    axis_pixel_t mem_q [FIFO_DEPTH];
    logic        do_push;
    logic        do_pop;

    // Extra pointer bit separates full from empty when the indices match.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge pixclk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
    end

endmodule

// File: rtl/d5m_axis_packer.sv
// D5M pixel bus to AXI4-Stream video; 1 cycle to FIFO (line end: cycle after ilval drops), 1 more to tvalid.
// Camera is never stalled: FIFO absorbs tready backpressure, drops on full set sticky overflow. Line stats: D5M_LINE_STATS_EN.
module d5m_axis_packer
    import generic_pack::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 16
) (
    input  logic              pixclk,
    input  logic              reset,
    input  logic              ifval,
    input  logic              ilval,
    input  logic [DATA_W-1:0] idata,
    input  logic              rgb_m_axis_tready,
    output logic              rgb_m_axis_tvalid,
    output logic              rgb_m_axis_tlast,
    output logic              rgb_m_axis_tuser,
    output logic [DATA_W-1:0] rgb_m_axis_tdata,
    output logic              overflow,
    output logic [CNT_W-1:0]  frame_count,
    output logic [CNT_W-1:0]  line_pixels,
    output logic [CNT_W-1:0]  frame_lines
);

    logic             ifval_q;
    logic             armed_q, armed_d;
    logic             sof_pending_q, sof_pending_d;
    logic             hold_vld_q, hold_vld_d;
    axis_pixel_t      hold_q, hold_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic             pix_vld;
    logic             fv_rise;
    logic             fv_fall;
    logic             push;
    axis_pixel_t      push_dat;
    logic             pop;
    axis_pixel_t      head;
    logic             fifo_full;
    logic             fifo_empty;

    assign pix_vld = armed_q && ifval && ilval;
    assign fv_rise = armed_q && ifval && !ifval_q;
    assign fv_fall = armed_q && !ifval && ifval_q;
    assign pop     = rgb_m_axis_tvalid && rgb_m_axis_tready;

    always_comb begin
        armed_d       = armed_q | !ifval;
        sof_pending_d = sof_pending_q | fv_rise;
        hold_vld_d    = pix_vld;
        hold_d        = hold_q;
        // The held pixel always leaves next cycle; whether a successor
        // arrived decides if it closed the line.
        push          = hold_vld_q;
        push_dat      = hold_q;
        push_dat.last = !pix_vld;
        if (pix_vld) begin
            hold_d.data   = idata;
            hold_d.user   = sof_pending_q | fv_rise;
            hold_d.last   = 1'b0;
            sof_pending_d = 1'b0;
        end
        frame_cnt_d = frame_cnt_q + {{(CNT_W-1){1'b0}}, fv_fall};
        overflow_d  = overflow_q | (push && fifo_full && !pop);
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            ifval_q       <= 1'b0;
            armed_q       <= 1'b0;
            sof_pending_q <= 1'b0;
            hold_vld_q    <= 1'b0;
            hold_q        <= '0;
            overflow_q    <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            ifval_q       <= ifval;
            armed_q       <= armed_d;
            sof_pending_q <= sof_pending_d;
            hold_vld_q    <= hold_vld_d;
            hold_q        <= hold_d;
            overflow_q    <= overflow_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    d5m_axis_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .pixclk     (pixclk),
        .reset      (reset),
        .push_i     (push),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .head_o     (head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty)
    );

    // Head is gated so idle outputs read 0 instead of stale storage.
    assign rgb_m_axis_tvalid = !fifo_empty;
    assign rgb_m_axis_tdata  = fifo_empty ? '0   : head.data;
    assign rgb_m_axis_tlast  = fifo_empty ? 1'b0 : head.last;
    assign rgb_m_axis_tuser  = fifo_empty ? 1'b0 : head.user;
    assign overflow          = overflow_q;
    assign frame_count       = frame_cnt_q;

`ifdef D5M_LINE_STATS_EN
    logic             pix_vld_q;
    logic             line_end;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [CNT_W-1:0] line_pixels_q, line_pixels_d;
    logic [CNT_W-1:0] frame_lines_q, frame_lines_d;
    logic [CNT_W-1:0] line_cnt_inc;

    assign line_end     = pix_vld_q && !pix_vld;
    assign line_cnt_inc = (&line_cnt_q) ? line_cnt_q : line_cnt_q + 1'b1;

    always_comb begin
        pix_cnt_d     = pix_cnt_q;
        line_cnt_d    = line_cnt_q;
        line_pixels_d = line_pixels_q;
        frame_lines_d = frame_lines_q;
        if (pix_vld) begin
            if (!pix_vld_q)       pix_cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
            else if (!(&pix_cnt_q)) pix_cnt_d = pix_cnt_q + 1'b1;
        end
        if (line_end) line_pixels_d = pix_cnt_q;
        // A line closed by the ifval fall itself still counts toward the frame.
        if (fv_fall) begin
            frame_lines_d = line_end ? line_cnt_inc : line_cnt_q;
            line_cnt_d    = '0;
        end else if (fv_rise) begin
            line_cnt_d = '0;
        end else if (line_end) begin
            line_cnt_d = line_cnt_inc;
        end
    end

    always_ff @(posedge pixclk) begin
        if (reset) begin
            pix_vld_q     <= 1'b0;
            pix_cnt_q     <= '0;
            line_cnt_q    <= '0;
            line_pixels_q <= '0;
            frame_lines_q <= '0;
        end else begin
            pix_vld_q     <= pix_vld;
            pix_cnt_q     <= pix_cnt_d;
            line_cnt_q    <= line_cnt_d;
            line_pixels_q <= line_pixels_d;
            frame_lines_q <= frame_lines_d;
        end
    end

    assign line_pixels = line_pixels_q;
    assign frame_lines = frame_lines_q;
`else
    assign line_pixels = '0;
    assign frame_lines = '0;
`endif

endmodule

// File: tb/tb_d5m_axis_packer.sv
// Directed bench for d5m_axis_packer: arming, framing flags, latency, overflow, stalls, line stats.
module tb_d5m_axis_packer;

    localparam int DW    = 24;
    localparam int DEPTH = 16;
    localparam int CW    = 16;

    logic          pixclk = 1'b0;
    logic          reset;
    logic          ifval;
    logic          ilval;
    logic [DW-1:0] idata;
    logic          tready;
    logic          tvalid;
    logic          tlast;
    logic          tuser;
    logic [DW-1:0] tdata;
    logic          overflow;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] line_pixels;
    logic [CW-1:0] frame_lines;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] bd[$];
    logic          bl[$];
    logic          bu[$];

    always #5 pixclk = ~pixclk;

    d5m_axis_packer #(
        .DATA_W     (DW),
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (CW)
    ) dut (
        .pixclk            (pixclk),
        .reset             (reset),
        .ifval             (ifval),
        .ilval             (ilval),
        .idata             (idata),
        .rgb_m_axis_tready (tready),
        .rgb_m_axis_tvalid (tvalid),
        .rgb_m_axis_tlast  (tlast),
        .rgb_m_axis_tuser  (tuser),
        .rgb_m_axis_tdata  (tdata),
        .overflow          (overflow),
        .frame_count       (frame_count),
        .line_pixels       (line_pixels),
        .frame_lines       (frame_lines)
    );

    // Record every accepted beat; values are stable at the falling edge.
    always @(negedge pixclk) begin
        if (!reset && tvalid && tready) begin
            bd.push_back(tdata);
            bl.push_back(tlast);
            bu.push_back(tuser);
        end
    end

    task automatic step(input int fv, input int lv, input int d);
        ifval = (fv != 0);
        ilval = (lv != 0);
        idata = d[DW-1:0];
        @(posedge pixclk);
        #1;
    endtask

    task automatic send_frame(input int nl, input int ppl, input int base);
        int d = base;
        step(1, 0, 0);
        step(1, 0, 0);
        for (int l = 0; l < nl; l++) begin
            for (int p = 0; p < ppl; p++) begin
                step(1, 1, d);
                d++;
            end
            step(1, 0, 0);
            step(1, 0, 0);
        end
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic drain(input int need);
        int n = 0;
        while (bd.size() < need && n < 300) begin
            @(posedge pixclk);
            #1;
            n++;
        end
        repeat (3) begin
            @(posedge pixclk);
            #1;
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        ifval  = 1'b1;
        ilval  = 1'b0;
        idata  = '0;
        tready = 1'b1;
        repeat (3) begin
            @(posedge pixclk);
            #1;
        end
        checks++;
        if ({tvalid, tlast, tuser, overflow} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000", {tvalid, tlast, tuser, overflow});
        end
        checks++;
        if ({tdata, frame_count, line_pixels, frame_lines} !== '0) begin
            errors++;
            $display("FAIL reset_values: tdata=%h fc=%0d lp=%0d fl=%0d want all 0",
                     tdata, frame_count, line_pixels, frame_lines);
        end
    endtask

    task automatic test_mid_frame_arming();
        logic seen = 1'b0;
        reset = 1'b0;
        for (int p = 0; p < 4; p++) begin
            step(1, 1, 'h50 + p);
            seen |= tvalid;
        end
        step(1, 0, 0);
        seen |= tvalid;
        step(0, 0, 0);
        step(0, 0, 0);
        seen |= tvalid;
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL arm_drop: tvalid seen=%b want 0", seen);
        end
        checks++;
        if (frame_count !== 16'd0) begin
            errors++;
            $display("FAIL arm_frame_count: got %0d want 0", frame_count);
        end
        bd.delete(); bl.delete(); bu.delete();
        send_frame(2, 4, 'h10);
        drain(8);
        checks++;
        if (bd.size() != 8) begin
            errors++;
            $display("FAIL arm_beats: got %0d want 8", bd.size());
        end
        for (int i = 0; i < bd.size() && i < 8; i++) begin
            logic [DW-1:0] ed = DW'('h10 + i);
            checks++;
            if ({bu[i], bl[i], bd[i]} !== {(i == 0), (i == 3 || i == 7), ed}) begin
                errors++;
                $display("FAIL arm_beat%0d: got u=%b l=%b d=%h want u=%b l=%b d=%h",
                         i, bu[i], bl[i], bd[i], (i == 0), (i == 3 || i == 7), ed);
            end
        end
        checks++;
        if (frame_count !== 16'd1) begin
            errors++;
            $display("FAIL arm_fc: got %0d want 1", frame_count);
        end
    endtask

    task automatic test_latency();
        bd.delete(); bl.delete(); bu.delete();
        step(1, 0, 0);
        step(1, 0, 0);
        for (int p = 1; p <= 3; p++) step(1, 1, p);
        checks++;
        if ({tvalid, tlast, tdata} !== {1'b1, 1'b0, 24'h000002}) begin
            errors++;
            $display("FAIL lat_mid: got v=%b l=%b d=%h want v=1 l=0 d=000002", tvalid, tlast, tdata);
        end
        step(1, 0, 0);
        checks++;
        if ({tvalid, tlast, tdata} !== {1'b1, 1'b1, 24'h000003}) begin
            errors++;
            $display("FAIL lat_eol: got v=%b l=%b d=%h want v=1 l=1 d=000003", tvalid, tlast, tdata);
        end
        step(1, 0, 0);
        for (int p = 4; p <= 6; p++) step(1, 1, p);
        step(1, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        drain(6);
        checks++;
        if (bd.size() != 6) begin
            errors++;
            $display("FAIL lat_beats: got %0d want 6", bd.size());
        end
        for (int i = 0; i < bd.size() && i < 6; i++) begin
            logic [DW-1:0] ed = DW'(i + 1);
            checks++;
            if ({bu[i], bl[i], bd[i]} !== {(i == 0), (i == 2 || i == 5), ed}) begin
                errors++;
                $display("FAIL lat_beat%0d: got u=%b l=%b d=%h want u=%b l=%b d=%h",
                         i, bu[i], bl[i], bd[i], (i == 0), (i == 2 || i == 5), ed);
            end
        end
        checks++;
        if (frame_count !== 16'd2) begin
            errors++;
            $display("FAIL lat_fc: got %0d want 2", frame_count);
        end
    endtask

    task automatic test_overflow();
        bd.delete(); bl.delete(); bu.delete();
        tready = 1'b0;
        send_frame(1, 20, 'h100);
        checks++;
        if ({overflow, tvalid, tuser, tdata} !== {1'b1, 1'b1, 1'b1, 24'h000100}) begin
            errors++;
            $display("FAIL ovf_full: got ovf=%b v=%b u=%b d=%h want ovf=1 v=1 u=1 d=000100",
                     overflow, tvalid, tuser, tdata);
        end
        tready = 1'b1;
        drain(DEPTH);
        checks++;
        if (bd.size() != DEPTH) begin
            errors++;
            $display("FAIL ovf_beats: got %0d want %0d", bd.size(), DEPTH);
        end
        for (int i = 0; i < bd.size() && i < DEPTH; i++) begin
            logic [DW-1:0] ed = DW'('h100 + i);
            checks++;
            if ({bu[i], bl[i], bd[i]} !== {(i == 0), 1'b0, ed}) begin
                errors++;
                $display("FAIL ovf_beat%0d: got u=%b l=%b d=%h want u=%b l=0 d=%h",
                         i, bu[i], bl[i], bd[i], (i == 0), ed);
            end
        end
        checks++;
        if ({overflow, frame_count} !== {1'b1, 16'd3}) begin
            errors++;
            $display("FAIL ovf_sticky: got ovf=%b fc=%0d want ovf=1 fc=3", overflow, frame_count);
        end
        reset = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        reset = 1'b0;
        step(0, 0, 0);
        checks++;
        if ({overflow, tvalid, frame_count} !== {1'b0, 1'b0, 16'd0}) begin
            errors++;
            $display("FAIL ovf_clear: got ovf=%b v=%b fc=%0d want 0 0 0", overflow, tvalid, frame_count);
        end
    endtask

    task automatic test_backpressure_toggle();
        logic          stop = 1'b0;
        logic          prev_stall = 1'b0;
        logic [DW+1:0] prev_head = '0;
        bd.delete(); bl.delete(); bu.delete();
        fork
            begin
                send_frame(3, 3, 'h200);
                stop = 1'b1;
            end
            while (!stop) begin
                @(posedge pixclk);
                #2;
                tready = ~tready;
            end
            while (!stop) begin
                @(negedge pixclk);
                if (prev_stall) begin
                    checks++;
                    if ({tvalid, tuser, tlast, tdata} !== {1'b1, prev_head}) begin
                        errors++;
                        $display("FAIL stall_hold: got v=%b {u,l,d}=%h want v=1 %h",
                                 tvalid, {tuser, tlast, tdata}, prev_head);
                    end
                end
                prev_stall = tvalid && !tready;
                prev_head  = {tuser, tlast, tdata};
            end
        join
        tready = 1'b1;
        drain(9);
        checks++;
        if (bd.size() != 9) begin
            errors++;
            $display("FAIL tog_beats: got %0d want 9", bd.size());
        end
        for (int i = 0; i < bd.size() && i < 9; i++) begin
            logic [DW-1:0] ed = DW'('h200 + i);
            checks++;
            if ({bu[i], bl[i], bd[i]} !== {(i == 0), (i % 3 == 2), ed}) begin
                errors++;
                $display("FAIL tog_beat%0d: got u=%b l=%b d=%h want u=%b l=%b d=%h",
                         i, bu[i], bl[i], bd[i], (i == 0), (i % 3 == 2), ed);
            end
        end
        checks++;
        if ({overflow, frame_count} !== {1'b0, 16'd1}) begin
            errors++;
            $display("FAIL tog_status: got ovf=%b fc=%0d want ovf=0 fc=1", overflow, frame_count);
        end
    endtask

    task automatic test_single_pixel_lines();
        bd.delete(); bl.delete(); bu.delete();
        step(1, 0, 0);
        step(1, 0, 0);
        for (int l = 0; l < 3; l++) begin
            step(1, 1, 'h300 + l);
            step(1, 0, 0);
            step(1, 0, 0);
        end
        step(0, 0, 0);
        step(0, 0, 0);
        drain(3);
        checks++;
        if (bd.size() != 3) begin
            errors++;
            $display("FAIL single_beats: got %0d want 3", bd.size());
        end
        for (int i = 0; i < bd.size() && i < 3; i++) begin
            logic [DW-1:0] ed = DW'('h300 + i);
            checks++;
            if ({bu[i], bl[i], bd[i]} !== {(i == 0), 1'b1, ed}) begin
                errors++;
                $display("FAIL single_beat%0d: got u=%b l=%b d=%h want u=%b l=1 d=%h",
                         i, bu[i], bl[i], bd[i], (i == 0), ed);
            end
        end
        checks++;
        if (frame_count !== 16'd2) begin
            errors++;
            $display("FAIL single_fc: got %0d want 2", frame_count);
        end
    endtask

    task automatic test_line_stats();
        logic [CW-1:0] exp_lp;
        logic [CW-1:0] exp_fl;
`ifdef D5M_LINE_STATS_EN
        exp_lp = 16'd7;
        exp_fl = 16'd5;
`else
        exp_lp = 16'd0;
        exp_fl = 16'd0;
`endif
        bd.delete(); bl.delete(); bu.delete();
        step(1, 0, 0);
        step(1, 0, 0);
        for (int l = 0; l < 5; l++) begin
            for (int p = 0; p < 7; p++) step(1, 1, 'h400 + l * 7 + p);
            step(1, 0, 0);
            checks++;
            if (line_pixels !== exp_lp) begin
                errors++;
                $display("FAIL stats_line%0d: line_pixels got %0d want %0d", l, line_pixels, exp_lp);
            end
            step(1, 0, 0);
        end
        step(0, 0, 0);
        checks++;
        if (frame_lines !== exp_fl) begin
            errors++;
            $display("FAIL stats_frame: frame_lines got %0d want %0d", frame_lines, exp_fl);
        end
        step(0, 0, 0);
        drain(35);
        checks++;
        if ({bd.size() == 35, frame_count} !== {1'b1, 16'd3}) begin
            errors++;
            $display("FAIL stats_drain: beats=%0d fc=%0d want beats=35 fc=3", bd.size(), frame_count);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mid_frame_arming();
        test_latency();
        test_overflow();
        test_backpressure_toggle();
        test_single_pixel_lines();
        test_line_stats();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
